// File: rtl/prog_tick_counter.sv
// ---------------------------------------------------------------------------
// prog_tick_counter
//
// Programmable time-base counter. A prescaler divides the crystal clock by
// DIV to produce a one-cycle tick. Each tick advances a modulo-MODULO counter,
// either up or down. The counter supports a synchronous load, a count enable
// and a terminal-count pulse when q wraps.
//
// Parameters
//   WIDTH   counter width in bits
//   MODULO  count range 0..MODULO-1, with 2 <= MODULO <= 2**WIDTH
//   DIV     crystal cycles per tick, DIV >= 1
//
// Ports
//   f_crystal  in   system clock; all logic runs on the rising edge
//   rst        in   synchronous reset, active-high
//   en         in   count enable; 0 freezes the prescaler and the counter
//   up_dn      in   direction: 1 = up, 0 = down (sampled on tick edges)
//   load       in   synchronous load strobe; overrides en
//   load_val   in   value loaded into q, clamped to MODULO-1
//   q          out  registered counter value
//   tick       out  registered one-cycle pulse per elapsed DIV interval
//   tc         out  registered one-cycle pulse when q wraps
//
// Priority on each edge: rst > load > en-count > hold.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module prog_tick_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16,
  parameter int DIV    = 100000000
) (
  input  logic             f_crystal,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc
);

  // With DIV = 1 the prescaler never leaves 0, but it still needs one bit.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] Q_LAST     = WIDTH'(MODULO - 1);

  // Catch illegal parameter sets at elaboration instead of in the lab.
  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("prog_tick_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end
  if (DIV < 1) begin : g_bad_div
    $error("prog_tick_counter: DIV must be at least 1");
  end

  // Saturate an out-of-range load value to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (v > Q_LAST) begin
      return Q_LAST;
    end
    return v;
  endfunction

  // Next value of q on a tick, in either direction. The wrap flag is raised
  // when the counter leaves its terminal value.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] cur,
                                                 input logic             dir_up);
    logic [WIDTH-1:0] nxt;
    logic             wrap;
    nxt  = cur;
    wrap = 1'b0;
    if (dir_up) begin
      if (cur == Q_LAST) begin
        nxt  = '0;
        wrap = 1'b1;
      end else begin
        nxt = cur + 1'b1;
      end
    end else begin
      if (cur == '0) begin
        nxt  = Q_LAST;
        wrap = 1'b1;
      end else begin
        nxt = cur - 1'b1;
      end
    end
    return {wrap, nxt};
  endfunction

  logic [PW-1:0]    presc_p0;
  logic [WIDTH-1:0] cnt_p0;
  logic             tick_p0;
  logic             tc_p0;

  logic [PW-1:0]    presc_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tick_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH:0]   stepped;

  // When MODULO fills the whole binary range every load value is legal and
  // the clamp compare would be constant, so it is left out entirely.
  if (MODULO < (1 << WIDTH)) begin : g_clamp
    assign load_clamped = clamp_load(load_val);
  end else begin : g_no_clamp
    assign load_clamped = load_val;
  end

  assign stepped = step_count(cnt_p0, up_dn);

  always_comb begin
    presc_nxt = presc_p0;
    cnt_nxt   = cnt_p0;
    tick_nxt  = 1'b0;
    tc_nxt    = 1'b0;
    if (load) begin
      // Load restarts the tick interval from this edge.
      cnt_nxt   = load_clamped;
      presc_nxt = '0;
    end else if (en) begin
      if (presc_p0 == PRESC_LAST) begin
        presc_nxt = '0;
        tick_nxt  = 1'b1;
        cnt_nxt   = stepped[WIDTH-1:0];
        tc_nxt    = stepped[WIDTH];
      end else begin
        presc_nxt = presc_p0 + 1'b1;
      end
    end
  end

  // ---- stage p0: state and output registers ----
  always_ff @(posedge f_crystal) begin
    if (rst) begin
      presc_p0 <= '0;
      cnt_p0   <= '0;
      tick_p0  <= 1'b0;
      tc_p0    <= 1'b0;
    end else begin
      presc_p0 <= presc_nxt;
      cnt_p0   <= cnt_nxt;
      tick_p0  <= tick_nxt;
      tc_p0    <= tc_nxt;
    end
  end

  assign q    = cnt_p0;
  assign tick = tick_p0;
  assign tc   = tc_p0;

endmodule

// File: tb/tb_prog_tick_counter.sv
module tb_prog_tick_counter;

  logic       clk;
  logic       rst, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tick, tc;

  logic       rst2, en2, up2, load2;
  logic [3:0] lv2;
  logic [3:0] q2;
  logic       tick2, tc2;

  int total = 0;
  int bad   = 0;

  prog_tick_counter #(.WIDTH(4), .MODULO(10), .DIV(4)) dut (
    .f_crystal(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q), .tick(tick), .tc(tc)
  );

  prog_tick_counter #(.WIDTH(4), .MODULO(16), .DIV(1)) dut2 (
    .f_crystal(clk), .rst(rst2), .en(en2), .up_dn(up2), .load(load2),
    .load_val(lv2), .q(q2), .tick(tick2), .tc(tc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check3(input string tag, input int qe, input int te,
                        input int ce);
    check({tag, ".q"},    {28'd0, q}, qe);
    check({tag, ".tick"}, {31'd0, tick}, te);
    check({tag, ".tc"},   {31'd0, tc}, ce);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    rst2 = 1'b1; en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; lv2 = 4'd0;

    // 1: reset, then count up for 44 cycles
    step();
    check3("reset", 0, 0, 0);
    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      step();
      check3($sformatf("up_c%0d", c), (c / 4) % 10, (c % 4 == 0) ? 1 : 0,
             (c == 40) ? 1 : 0);
    end

    // 2: load 0 with en low, then count down
    load = 1'b1; load_val = 4'd0; en = 1'b0;
    step();
    check3("load0", 0, 0, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      check3($sformatf("dn_c%0d", c), (c < 4) ? 0 : 10 - c / 4,
             (c % 4 == 0) ? 1 : 0, (c == 4) ? 1 : 0);
    end

    // 3: clamped load, interval restart, load beating a tick edge
    load = 1'b1; load_val = 4'd13;
    step();
    check3("load13", 9, 0, 0);
    load = 1'b0; up_dn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check3($sformatf("rst_iv_c%0d", c), (c == 4) ? 0 : 9,
             (c == 4) ? 1 : 0, (c == 4) ? 1 : 0);
    end
    step(); step(); step();
    check3("pre_wouldbe", 0, 0, 0);
    load = 1'b1; load_val = 4'd5;
    step();
    check3("load_wins", 5, 0, 0);
    load = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check3($sformatf("after_ld_c%0d", c), (c == 4) ? 6 : 5,
             (c == 4) ? 1 : 0, 0);
    end

    // 4: hold for 7 cycles after 2 prescaler counts
    step(); step();
    check3("pre_hold", 6, 0, 0);
    en = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step();
      check3($sformatf("hold_c%0d", c), 6, 0, 0);
    end
    en = 1'b1;
    step();
    check3("resume1", 6, 0, 0);
    step();
    check3("resume2", 7, 1, 0);

    // 5: reset mid-interval at q=6 with load on the same edge
    load = 1'b1; load_val = 4'd6;
    step();
    check3("load6", 6, 0, 0);
    load = 1'b0;
    step(); step();
    rst = 1'b1; load = 1'b1; load_val = 4'd3;
    step();
    check3("rst_wins", 0, 0, 0);
    rst = 1'b0; load = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check3($sformatf("post_rst_c%0d", c), (c == 4) ? 1 : 0,
             (c == 4) ? 1 : 0, 0);
    end
    load = 1'b1; load_val = 4'd15;
    step();
    check3("load15", 9, 0, 0);
    load = 1'b0;

    // 6: DIV=1, MODULO=16, up count
    step();
    check("d1_reset.q", {28'd0, q2}, 0);
    check("d1_reset.tick", {31'd0, tick2}, 0);
    rst2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      step();
      check($sformatf("d1_c%0d.q", c), {28'd0, q2}, c % 16);
      check($sformatf("d1_c%0d.tick", c), {31'd0, tick2}, 1);
      check($sformatf("d1_c%0d.tc", c), {31'd0, tc2}, (c % 16 == 0) ? 1 : 0);
    end
    en2 = 1'b0;
    step();
    check("d1_hold.q", {28'd0, q2}, 2);
    check("d1_hold.tick", {31'd0, tick2}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_tick_counter.md
Name: prog_tick_counter

Overview:
- Parametrised successor to the fixed 1 Hz divider plus 4-bit binary counter pair; both functions are merged into one synchronous block.
- A prescaler derives a one-cycle tick every DIV crystal cycles.
- The counter advances on each tick. Width, modulus and up/down direction are configurable, and the counter supports synchronous load, enable and terminal-count pulse.
- Sits between the board crystal and display/LED logic. Serves as the general time-base counter for later labs.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULO, 16, count range 0..MODULO-1; legal 2 <= MODULO <= 2**WIDTH.
- DIV, 100000000, crystal cycles per tick; legal DIV >= 1; prescaler width = clog2(DIV), minimum 1.

Ports:
- f_crystal  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; 0 freezes the prescaler and the counter.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded into q.
- q  output  WIDTH  counter value, registered.
- tick  output  1  registered one-cycle pulse per elapsed DIV interval.
- tc  output  1  registered one-cycle pulse when q wraps.

Behaviour:
- One clock, f_crystal. Reset is synchronous, active-high.
- Priority per edge: rst > load > en-count > hold.
- Reset:
  - Clears q, prescaler, tick and tc to 0 on the next edge.
  - Reset mid-interval discards the partial count; after release, the first tick occurs DIV enabled cycles later.
- Load (rst=0, load=1), regardless of en:
  - q <= load_val, clamped to MODULO-1 if load_val >= MODULO.
  - Prescaler <= 0; tick <= 0; tc <= 0.
  - The interval restarts from the load edge.
- Count (rst=0, load=0, en=1):
  - If prescaler != DIV-1: prescaler increments; tick <= 0; tc <= 0.
  - If prescaler == DIV-1: prescaler <= 0 and tick <= 1.
  - On that same edge, q updates:
    - up: q == MODULO-1 -> q <= 0 and tc <= 1; otherwise q+1, tc <= 0.
    - down: q == 0 -> q <= MODULO-1 and tc <= 1; otherwise q-1, tc <= 0.
  - up_dn is sampled only on the tick edge; changing it mid-interval has no effect until then.
- Hold (en=0):
  - Prescaler and q hold; tick <= 0; tc <= 0.
  - On re-enable, counting resumes from the held prescaler value; there is no restart.
- Timing:
  - q, tick and tc change on the same edge.
  - tick and tc are high for exactly one f_crystal cycle.
  - tc implies tick.
- DIV = 1: tick is high every enabled cycle after the first, and q steps every enabled cycle.
- MODULO = 2**WIDTH: wrap coincides with natural binary overflow. No extra compare is required, but the behaviour is identical.
- No combinational path from any input to any output.

Test Plan (WIDTH=4, MODULO=10, DIV=4 unless stated):
1. Reset then en=1, up_dn=1 for 44 cycles.
   - tick pulses on cycles 4, 8, …, 40, 44.
   - q runs 1..9 then 0 at cycle 40.
   - tc high only on cycle 40; q=1 at cycle 44.
2. Load with load_val=0, then en=1, up_dn=0.
   - First tick: q=9 with tc=1.
   - Next ticks: 8, 7, … with tc=0.
3. load=1, load_val=13.
   - q=9 next cycle.
   - Prescaler restarts: next tick exactly 4 enabled cycles after the load edge.
   - load asserted together with en=1 on a would-be tick edge -> load wins, tick=0.
4. en dropped for 7 cycles after 2 prescaler counts.
   - q, tick and tc are frozen/low while en=0.
   - After re-enable, tick arrives after 2 more cycles.
5. rst asserted mid-interval at q=6, with load=1 on the same edge.
   - q=0, tick=0, tc=0 (reset wins).
   - After release, first tick 4 cycles later with q=1.
6. DIV=1, MODULO=16, up count.
   - q increments every cycle.
   - tick high continuously while enabled.
   - tc pulses once per 16 cycles at the 15->0 wrap.
